// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encodings,
// error codes reported on err_code, and the default frame start marker.
// No ports; imported by uart_boot_loader and boot_timeout.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CKSUM,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CKSUM   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // States in which a frame is open and the inter-byte watchdog runs.
    function automatic logic in_frame(input boot_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CKSUM);
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog for the boot loader.
// Ports:
//   clk        system clock
//   sys_reset  synchronous reset, active-low
//   clear      restart the count (a byte arrived)
//   enable     count only while a frame is open; when low the count is held at 0
//   expired    high on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear
module boot_timeout
    import uart_boot_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturating counter; saturation only matters if the owner ignores expired.
    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_boot_loader.sv
// Turns the UART receiver byte stream into IMEM word writes.
// Frame: SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes (little-endian words), CKSUM (XOR of data).
// Ports:
//   clk, SYS_reset (sync, active-low)
//   rx_data/rx_done   byte stream from the UART receiver
//   imem_we/imem_addr/imem_wdata   registered IMEM write port, one strobe per word
//   cpu_hold   keeps the core in reset while loading and after a failed load
//   load_busy  frame in progress;  load_done  one-cycle success pulse
//   load_err/err_code   sticky error and its cause, cleared by the next SYNC
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 10,
    parameter int         BASE_ADDR      = 0,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  SYS_reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code
);

    localparam logic [16:0]           MAX_LEN = 17'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

    boot_state_t  state;
    logic [7:0]   len_lo;
    logic [16:0]  len;
    logic [16:0]  word_cnt;
    logic [1:0]   byte_idx;
    logic [23:0]  word_buf;
    logic [7:0]   cksum;
    logic [16:0]  new_len;
    logic         timed_out;

    assign new_len = {1'b0, rx_data, len_lo};

    boot_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .sys_reset(SYS_reset),
        .clear    (rx_done),
        .enable   (in_frame(state)),
        .expired  (timed_out)
    );

    // Frame parser. All outputs are registered here; imem_we and load_done are
    // single-cycle strobes so they default low every cycle.
    always_ff @(posedge clk) begin
        if (!SYS_reset) begin
            state      <= ST_IDLE;
            len_lo     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            cksum      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            if (timed_out) begin
                // cpu_hold stays high so a partial image never runs.
                state     <= ST_ERROR;
                load_err  <= 1'b1;
                load_busy <= 1'b0;
                err_code  <= ERR_TIMEOUT;
            end else begin
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (rx_done && rx_data == SYNC_BYTE) begin
                            state     <= ST_LEN_LO;
                            cpu_hold  <= 1'b1;
                            load_busy <= 1'b1;
                            load_err  <= 1'b0;
                            err_code  <= ERR_NONE;
                            cksum     <= '0;
                            byte_idx  <= '0;
                            word_cnt  <= '0;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_done) begin
                            len_lo <= rx_data;
                            state  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_done) begin
                            len <= new_len;
                            if (new_len > MAX_LEN) begin
                                state     <= ST_ERROR;
                                load_err  <= 1'b1;
                                load_busy <= 1'b0;
                                err_code  <= ERR_LEN;
                            end else if (new_len == '0) begin
                                state <= ST_CKSUM;
                            end else begin
                                state    <= ST_DATA;
                                word_cnt <= '0;
                                byte_idx <= '0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_done) begin
                            cksum    <= cksum ^ rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= rx_data;
                                2'd1: word_buf[15:8]  <= rx_data;
                                2'd2: word_buf[23:16] <= rx_data;
                                default: begin
                                    // Address wraps within the IMEM word space.
                                    imem_we    <= 1'b1;
                                    imem_addr  <= BASE + word_cnt[ADDR_WIDTH-1:0];
                                    imem_wdata <= {rx_data, word_buf};
                                    word_cnt   <= word_cnt + 17'd1;
                                    if (word_cnt + 17'd1 == len) begin
                                        state <= ST_CKSUM;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_CKSUM: begin
                        if (rx_done) begin
                            if (rx_data == cksum) begin
                                state     <= ST_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                                load_busy <= 1'b0;
                            end else begin
                                state     <= ST_ERROR;
                                load_err  <= 1'b1;
                                load_busy <= 1'b0;
                                err_code  <= ERR_CKSUM;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: stimulus pushes expected write /
// done / error events, a negedge monitor pops and compares them.
module tb_uart_boot_loader;

    localparam int AW = 4;
    localparam int TO = 16;

    localparam int K_NONE  = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    logic          clk = 1'b0;
    logic          SYS_reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [1:0]    err_code;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic err_prev = 1'b0;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (0),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .SYS_reset (SYS_reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One-cycle rx_done pulse followed by idle cycles; starts and ends just after a posedge.
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (idle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = K_WRITE; e.addr = a; e.data = d; e.code = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic expectDone();
        exp_t e;
        e.kind = K_DONE; e.addr = '0; e.data = '0; e.code = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic expectErr(input logic [1:0] c);
        exp_t e;
        e.kind = K_ERR; e.addr = '0; e.data = '0; e.code = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed write, done pulse or new error pops one expected event.
    always @(negedge clk) begin
        exp_t e;
        if (SYS_reset) begin
            if (imem_we) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e.kind = K_NONE;
                checkOutput("write event", e.kind, K_WRITE);
                if (e.kind == K_WRITE) begin
                    checkOutput("write addr", {28'd0, imem_addr}, e.addr);
                    checkOutput("write data", imem_wdata, e.data);
                end
            end
            if (load_done) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e.kind = K_NONE;
                checkOutput("done event", e.kind, K_DONE);
                checkOutput("done cpu_hold", {31'd0, cpu_hold}, 0);
                checkOutput("done load_busy", {31'd0, load_busy}, 0);
                checkOutput("done err_code", {30'd0, err_code}, 0);
            end
            if (load_err && !err_prev) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e.kind = K_NONE;
                checkOutput("error event", e.kind, K_ERR);
                if (e.kind == K_ERR) begin
                    checkOutput("error code", {30'd0, err_code}, {30'd0, e.code});
                end
                checkOutput("error cpu_hold", {31'd0, cpu_hold}, 1);
                checkOutput("error load_busy", {31'd0, load_busy}, 0);
            end
        end
        err_prev = load_err;
    end

    task automatic checkAllZero(input string name);
        checkOutput(name, {imem_we, imem_addr, imem_wdata, cpu_hold, load_busy,
                           load_done, load_err, err_code}, 0);
    endtask

    task automatic goodFrame();
        expectWrite(0, 32'h12345678);
        expectWrite(1, 32'hDEADBEEF);
        expectDone();
        applyStimulus(8'hA5, 0);
        checkOutput("sync clears load_err", {31'd0, load_err}, 0);
        checkOutput("sync sets cpu_hold", {31'd0, cpu_hold}, 1);
        checkOutput("sync sets load_busy", {31'd0, load_busy}, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, 1);
        applyStimulus(8'h56, 2);
        applyStimulus(8'h34, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'hEF, 1);
        applyStimulus(8'hBE, 1);
        applyStimulus(8'hAD, 1);
        applyStimulus(8'hDE, 0);
        checkOutput("write latency", {31'd0, imem_we}, 1);
        applyStimulus(8'h2A, 0);
        checkOutput("done latency", {31'd0, load_done}, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cpu released", {31'd0, cpu_hold}, 0);
    endtask

    initial begin
        SYS_reset = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset outputs");
        SYS_reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] test 1: two-word frame");
        goodFrame();

        $display("[TB] test 2: bad checksum then recovery");
        expectWrite(0, 32'h12345678);
        expectWrite(1, 32'hDEADBEEF);
        expectErr(2'd2);
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, 1);
        applyStimulus(8'h56, 1);
        applyStimulus(8'h34, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'hEF, 1);
        applyStimulus(8'hBE, 1);
        applyStimulus(8'hAD, 1);
        applyStimulus(8'hDE, 1);
        applyStimulus(8'h2B, 3);
        checkOutput("cksum err sticky", {31'd0, load_err}, 1);
        checkOutput("cksum hold kept", {31'd0, cpu_hold}, 1);
        goodFrame();

        $display("[TB] test 3: zero length");
        expectDone();
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h00, 3);

        $display("[TB] test 4: length too big");
        expectErr(2'd1);
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h00, 3);
        checkOutput("len err code", {30'd0, err_code}, 1);

        $display("[TB] test 5: timeout and byte on expiry cycle");
        expectErr(2'd3);
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, 1);
        applyStimulus(8'h56, 3 * TO);
        checkOutput("timeout err code", {30'd0, err_code}, 3);
        expectWrite(0, 32'h12345678);
        expectDone();
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, TO - 1);
        applyStimulus(8'h56, 1);
        applyStimulus(8'h34, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'h08, 3);
        checkOutput("expiry byte wins", {31'd0, load_err}, 0);

        $display("[TB] test 6: reset mid-frame");
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, 1);
        applyStimulus(8'h56, 1);
        SYS_reset = 1'b0;
        @(posedge clk); #1;
        checkAllZero("mid-frame reset outputs");
        SYS_reset = 1'b1;
        applyStimulus(8'h34, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'hEF, 1);
        applyStimulus(8'hDE, 1);
        applyStimulus(8'h2A, 2);
        checkAllZero("garbage ignored");
        expectWrite(0, 32'h44332211);
        expectDone();
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 1);
        applyStimulus(8'h33, 1);
        applyStimulus(8'h44, 1);
        applyStimulus(8'h44, 3);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
